// File: rtl/cpc_mem_arbiter_if.sv
// Bus bundle between the CPC motherboard requesters, the memory arbiter and the SDRAM front end.
// Handshake: a requester holds *_req high until its one-cycle *_ack; the arbiter strobes sdr_req
// for one cycle per command and the controller answers later with a one-cycle sdr_ready.
interface cpc_mem_arbiter_if #(
  parameter int AW = 23
);
  logic          vid_req;
  logic [AW-2:0] vid_addr;
  logic [15:0]   vid_data;
  logic          vid_ack;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din;
  logic [7:0]    cpu_dout;
  logic          cpu_ack;

  logic          ld_req;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [7:0]    ld_din;
  logic [7:0]    ld_dout;
  logic          ld_ack;

  logic          sdr_req;
  logic          sdr_we;
  logic [AW-2:0] sdr_addr;
  logic [15:0]   sdr_din;
  logic [1:0]    sdr_be;
  logic [15:0]   sdr_dout;
  logic          sdr_ready;

  logic [1:0]    owner;

  // slave: the arbiter itself; master: requesters plus memory controller around it
  modport slave (
    input  vid_req, vid_addr,
    output vid_data, vid_ack,
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    output cpu_dout, cpu_ack,
    input  ld_req, ld_we, ld_addr, ld_din,
    output ld_dout, ld_ack,
    output sdr_req, sdr_we, sdr_addr, sdr_din, sdr_be,
    input  sdr_dout, sdr_ready,
    output owner
  );

  modport master (
    output vid_req, vid_addr,
    input  vid_data, vid_ack,
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    input  cpu_dout, cpu_ack,
    output ld_req, ld_we, ld_addr, ld_din,
    input  ld_dout, ld_ack,
    input  sdr_req, sdr_we, sdr_addr, sdr_din, sdr_be,
    output sdr_dout, sdr_ready,
    input  owner
  );
endinterface

// File: rtl/cpc_mem_arbiter.sv
// Serialises video, CPU and loader accesses onto one 16-bit SDRAM port, splitting bytes into
// lanes; a pending loader wins once it has lost STARVE_LIMIT consecutive arbitrations.
module cpc_mem_arbiter #(
  parameter int AW           = 23,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  cpc_mem_arbiter_if.slave  bus,
  output logic [1:0]        dbg_state
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_LD   = 2'd3
  } owner_t;

  state_t        state;
  state_t        next_state;
  owner_t        owner_q;
  owner_t        grant;
  logic [CW-1:0] starve_cnt;
  logic          starved;
  logic          lane_hi;
  logic [7:0]    rd_byte;

  assign starved   = starve_cnt >= CW'(STARVE_LIMIT);
  assign rd_byte   = lane_hi ? bus.sdr_dout[15:8] : bus.sdr_dout[7:0];
  assign bus.owner = owner_q;
  assign dbg_state = state;

  always_comb begin
    grant = OWN_NONE;
    if (bus.ld_req && starved) grant = OWN_LD;
    else if (bus.vid_req)      grant = OWN_VID;
    else if (bus.cpu_req)      grant = OWN_CPU;
    else if (bus.ld_req)       grant = OWN_LD;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (grant != OWN_NONE) next_state = S_ISSUE;
      S_ISSUE: next_state = S_WAIT;
      S_WAIT:  if (bus.sdr_ready) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Command fields are registered at grant, so they stay stable through ISSUE and WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q      <= OWN_NONE;
      lane_hi      <= 1'b0;
      bus.sdr_req  <= 1'b0;
      bus.sdr_we   <= 1'b0;
      bus.sdr_addr <= '0;
      bus.sdr_din  <= '0;
      bus.sdr_be   <= 2'b00;
      bus.vid_ack  <= 1'b0;
      bus.cpu_ack  <= 1'b0;
      bus.ld_ack   <= 1'b0;
      bus.vid_data <= '0;
      bus.cpu_dout <= '0;
      bus.ld_dout  <= '0;
    end else begin
      bus.sdr_req <= 1'b0;
      bus.vid_ack <= 1'b0;
      bus.cpu_ack <= 1'b0;
      bus.ld_ack  <= 1'b0;
      case (state)
        S_IDLE: begin
          owner_q <= grant;
          case (grant)
            OWN_VID: begin
              bus.sdr_req  <= 1'b1;
              bus.sdr_we   <= 1'b0;
              bus.sdr_addr <= bus.vid_addr;
              bus.sdr_be   <= 2'b11;
              bus.sdr_din  <= '0;
              lane_hi      <= 1'b0;
            end
            OWN_CPU: begin
              bus.sdr_req  <= 1'b1;
              bus.sdr_we   <= bus.cpu_we;
              bus.sdr_addr <= bus.cpu_addr[AW-1:1];
              bus.sdr_be   <= bus.cpu_addr[0] ? 2'b10 : 2'b01;
              bus.sdr_din  <= {bus.cpu_din, bus.cpu_din};
              lane_hi      <= bus.cpu_addr[0];
            end
            OWN_LD: begin
              bus.sdr_req  <= 1'b1;
              bus.sdr_we   <= bus.ld_we;
              bus.sdr_addr <= bus.ld_addr[AW-1:1];
              bus.sdr_be   <= bus.ld_addr[0] ? 2'b10 : 2'b01;
              bus.sdr_din  <= {bus.ld_din, bus.ld_din};
              lane_hi      <= bus.ld_addr[0];
            end
            default: ;
          endcase
        end
        S_WAIT: begin
          if (bus.sdr_ready) begin
            case (owner_q)
              OWN_VID: begin
                bus.vid_ack  <= 1'b1;
                bus.vid_data <= bus.sdr_dout;
              end
              OWN_CPU: begin
                bus.cpu_ack <= 1'b1;
                if (!bus.sdr_we) bus.cpu_dout <= rd_byte;
              end
              OWN_LD: begin
                bus.ld_ack <= 1'b1;
                if (!bus.sdr_we) bus.ld_dout <= rd_byte;
              end
              default: ;
            endcase
          end
        end
        S_DONE:  owner_q <= OWN_NONE;
        default: ;
      endcase
    end
  end

  // Counts lost arbitrations only while the loader is actually waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!bus.ld_req) begin
      starve_cnt <= '0;
    end else if (state == S_IDLE) begin
      if (grant == OWN_LD)
        starve_cnt <= '0;
      else if (grant != OWN_NONE && !starved)
        starve_cnt <= starve_cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_cpc_mem_arbiter.sv
// Bench for cpc_mem_arbiter: SDRAM responder with a word memory, byte-level reference memory,
// directed scenarios and randomized single transactions.
module tb_cpc_mem_arbiter;
  localparam int AW    = 23;
  localparam int WAW   = AW - 1;
  localparam int LIMIT = 8;

  typedef struct packed {
    logic [1:0]  who;
    logic [15:0] data;
  } ack_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         errors = 0;

  cpc_mem_arbiter_if #(.AW(AW)) bus ();

  cpc_mem_arbiter #(.AW(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  // ---------------- memory controller model + logs ----------------
  logic [15:0]   mem [int];
  logic [7:0]    ref_mem [int];
  int            lat = 2;
  bit            resp_en = 1'b1;
  logic [WAW-1:0] cmd_addr;
  logic          cmd_we;
  logic [1:0]    cmd_be;
  logic [15:0]   cmd_din;
  logic [1:0]    own_log [$];
  logic [1:0]    exp_q [$];
  ack_t          ack_log [$];
  logic [7:0]    m_cpu_dout = 8'h00;
  logic [7:0]    m_ld_dout  = 8'h00;

  function automatic logic [15:0] word_init(input int w);
    return 16'(w) ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] rd_word(input int w);
    return mem.exists(w) ? mem[w] : word_init(w);
  endfunction

  function automatic logic [7:0] ref_rd(input int a);
    logic [15:0] w;
    if (ref_mem.exists(a)) return ref_mem[a];
    w = word_init(a >> 1);
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  initial begin : responder
    int w;
    logic [15:0] cur;
    bus.sdr_ready = 1'b0;
    bus.sdr_dout  = 16'h0000;
    forever begin
      @(posedge clk); #1;
      if (bus.sdr_req === 1'b1 && resp_en) begin
        w        = int'(bus.sdr_addr);
        cmd_addr = bus.sdr_addr;
        cmd_we   = bus.sdr_we;
        cmd_be   = bus.sdr_be;
        cmd_din  = bus.sdr_din;
        own_log.push_back(bus.owner);
        cur = rd_word(w);
        if (bus.sdr_we) begin
          if (bus.sdr_be[1]) cur[15:8] = bus.sdr_din[15:8];
          if (bus.sdr_be[0]) cur[7:0]  = bus.sdr_din[7:0];
          mem[w] = cur;
        end
        repeat (lat) @(posedge clk);
        #1;
        bus.sdr_ready = 1'b1;
        bus.sdr_dout  = cur;
        @(posedge clk); #1;
        bus.sdr_ready = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.vid_ack === 1'b1) ack_log.push_back({2'd1, bus.vid_data});
    if (bus.cpu_ack === 1'b1) ack_log.push_back({2'd2, 8'h00, bus.cpu_dout});
    if (bus.ld_ack === 1'b1)  ack_log.push_back({2'd3, 8'h00, bus.ld_dout});
  end

  // ---------------- driver ----------------
  // One transaction from one requester; inputs are scrambled once the command is latched.
  task automatic run_txn(input int who, input logic we, input logic [AW-1:0] addr,
                         input logic [7:0] din, output bit ok, output int cycles);
    @(negedge clk);
    case (who)
      1: begin bus.vid_req = 1'b1; bus.vid_addr = addr[AW-1:1]; end
      2: begin bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_din = din; end
      default: begin bus.ld_req = 1'b1; bus.ld_we = we; bus.ld_addr = addr; bus.ld_din = din; end
    endcase
    ok = 1'b0;
    cycles = 0;
    for (int k = 1; k <= 60 && !ok; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.vid_addr = WAW'($urandom);
        bus.cpu_addr = AW'($urandom);
        bus.cpu_din  = 8'($urandom);
        bus.cpu_we   = ~we;
        bus.ld_addr  = AW'($urandom);
        bus.ld_din   = 8'($urandom);
        bus.ld_we    = ~we;
      end
      if ((who == 1 && bus.vid_ack === 1'b1) || (who == 2 && bus.cpu_ack === 1'b1) ||
          (who == 3 && bus.ld_ack === 1'b1)) begin
        ok = 1'b1;
        cycles = k;
      end
    end
    bus.vid_req = 1'b0;
    bus.cpu_req = 1'b0;
    bus.ld_req  = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.vid_ack, bus.cpu_ack, bus.ld_ack, bus.sdr_req, bus.sdr_we, bus.owner} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0000000",
               {bus.vid_ack, bus.cpu_ack, bus.ld_ack, bus.sdr_req, bus.sdr_we, bus.owner});
    end
    checks++;
    if ({bus.sdr_addr, bus.sdr_din, bus.sdr_be} !== '0) begin
      errors++;
      $display("FAIL reset_cmd got addr=%h din=%h be=%b want zeros", bus.sdr_addr, bus.sdr_din, bus.sdr_be);
    end
    checks++;
    if ({bus.vid_data, bus.cpu_dout, bus.ld_dout} !== '0) begin
      errors++;
      $display("FAIL reset_data got vid=%h cpu=%h ld=%h want zeros", bus.vid_data, bus.cpu_dout, bus.ld_dout);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.owner !== 2'd0 || bus.sdr_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req got owner=%0d sdr_req=%b want 0 0", bus.owner, bus.sdr_req);
    end
  endtask

  task automatic test_cpu_write;
    bit ok;
    int cyc;
    int n0;
    lat = 2;
    n0 = ack_log.size();
    run_txn(2, 1'b1, 23'h000011, 8'hA5, ok, cyc);
    ref_mem[17] = 8'hA5;
    checks++;
    if (!ok) begin errors++; $display("FAIL wr_ack got timeout want cpu_ack"); end
    checks++;
    if (cmd_addr !== 22'h000008) begin errors++; $display("FAIL wr_addr got %h want 000008", cmd_addr); end
    checks++;
    if (cmd_be !== 2'b10) begin errors++; $display("FAIL wr_be got %b want 10", cmd_be); end
    checks++;
    if (cmd_din !== 16'hA5A5) begin errors++; $display("FAIL wr_din got %h want a5a5", cmd_din); end
    checks++;
    if (cmd_we !== 1'b1) begin errors++; $display("FAIL wr_we got %b want 1", cmd_we); end
    checks++;
    if (cyc != 4) begin errors++; $display("FAIL wr_latency got %0d want 4", cyc); end
    checks++;
    if (bus.cpu_dout !== m_cpu_dout) begin
      errors++;
      $display("FAIL wr_dout_kept got %h want %h", bus.cpu_dout, m_cpu_dout);
    end
    checks++;
    if (ack_log.size() != n0 + 1) begin
      errors++;
      $display("FAIL wr_ack_width got %0d ack cycles want 1", ack_log.size() - n0);
    end
  endtask

  task automatic test_cpu_read;
    bit ok;
    int cyc;
    int n0;
    mem[8] = 16'h1234;
    ref_mem[16] = 8'h34;
    ref_mem[17] = 8'h12;
    n0 = ack_log.size();
    run_txn(2, 1'b0, 23'h000010, 8'h00, ok, cyc);
    m_cpu_dout = ref_rd(16);
    checks++;
    if (!ok || bus.cpu_dout !== 8'h34) begin
      errors++;
      $display("FAIL rd_even got ok=%0d dout=%h want 1 34", ok, bus.cpu_dout);
    end
    checks++;
    if (ack_log.size() != n0 + 1) begin
      errors++;
      $display("FAIL rd_ack_width got %0d ack cycles want 1", ack_log.size() - n0);
    end
    checks++;
    if (own_log.size() == 0 || own_log[own_log.size()-1] !== 2'd2 || bus.owner !== 2'd0) begin
      errors++;
      $display("FAIL rd_owner got now=%0d want granted 2 then 0", bus.owner);
    end
    run_txn(2, 1'b0, 23'h000011, 8'h00, ok, cyc);
    m_cpu_dout = ref_rd(17);
    checks++;
    if (!ok || bus.cpu_dout !== m_cpu_dout) begin
      errors++;
      $display("FAIL rd_odd got ok=%0d dout=%h want 1 %h", ok, bus.cpu_dout, m_cpu_dout);
    end
  endtask

  task automatic test_simultaneous;
    bit vd, cd, ld;
    lat = 1;
    own_log.delete();
    ack_log.delete();
    exp_q = '{2'd1, 2'd2, 2'd3};
    vd = 1'b0; cd = 1'b0; ld = 1'b0;
    @(negedge clk);
    bus.vid_req = 1'b1; bus.vid_addr = 22'h000100;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 23'h000205;
    bus.ld_req  = 1'b1; bus.ld_we  = 1'b0; bus.ld_addr  = 23'h000302;
    for (int k = 0; k < 100 && !(vd && cd && ld); k++) begin
      @(negedge clk);
      if (bus.vid_ack === 1'b1) begin bus.vid_req = 1'b0; vd = 1'b1; end
      if (bus.cpu_ack === 1'b1) begin bus.cpu_req = 1'b0; cd = 1'b1; end
      if (bus.ld_ack === 1'b1)  begin bus.ld_req  = 1'b0; ld = 1'b1; end
    end
    bus.vid_req = 1'b0; bus.cpu_req = 1'b0; bus.ld_req = 1'b0;
    @(negedge clk);
    m_cpu_dout = ref_rd(32'h205);
    m_ld_dout  = ref_rd(32'h302);
    checks++;
    if (own_log.size() != 3 || ack_log.size() != 3) begin
      errors++;
      $display("FAIL sim_count got grants=%0d acks=%0d want 3 3", own_log.size(), ack_log.size());
    end
    for (int i = 0; i < 3 && i < own_log.size() && i < ack_log.size(); i++) begin
      checks++;
      if (own_log[i] !== exp_q[i] || ack_log[i].who !== exp_q[i]) begin
        errors++;
        $display("FAIL sim_order[%0d] got grant=%0d ack=%0d want %0d", i, own_log[i], ack_log[i].who, exp_q[i]);
      end
    end
    checks++;
    if (bus.vid_data !== {ref_rd(32'h201), ref_rd(32'h200)}) begin
      errors++;
      $display("FAIL sim_vid_data got %h want %h", bus.vid_data, {ref_rd(32'h201), ref_rd(32'h200)});
    end
    checks++;
    if (bus.cpu_dout !== m_cpu_dout || bus.ld_dout !== m_ld_dout) begin
      errors++;
      $display("FAIL sim_bytes got cpu=%h ld=%h want %h %h", bus.cpu_dout, bus.ld_dout, m_cpu_dout, m_ld_dout);
    end
  endtask

  task automatic test_starvation;
    int ld_seen;
    int cnt;
    lat = 1;
    own_log.delete();
    ack_log.delete();
    exp_q.delete();
    cnt = 0;
    for (int g = 0; g < 2 * (LIMIT + 1); g++) begin
      if (cnt == LIMIT) begin exp_q.push_back(2'd3); cnt = 0; end
      else begin exp_q.push_back(2'd1); cnt++; end
    end
    ld_seen = 0;
    @(negedge clk);
    bus.vid_req = 1'b1; bus.vid_addr = 22'h000000;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 23'h000004;
    bus.ld_req  = 1'b1; bus.ld_we  = 1'b0; bus.ld_addr  = 23'h000006;
    for (int k = 0; k < 400 && ld_seen < 2; k++) begin
      @(negedge clk);
      if (bus.ld_ack === 1'b1) ld_seen++;
    end
    bus.vid_req = 1'b0; bus.cpu_req = 1'b0; bus.ld_req = 1'b0;
    repeat (8) @(negedge clk);
    m_ld_dout = ref_rd(6);
    checks++;
    if (own_log.size() != exp_q.size()) begin
      errors++;
      $display("FAIL starve_count got %0d grants want %0d", own_log.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < own_log.size(); i++) begin
      checks++;
      if (own_log[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL starve_grant[%0d] got %0d want %0d", i, own_log[i], exp_q[i]);
      end
    end
    checks++;
    if (bus.ld_dout !== m_ld_dout) begin
      errors++;
      $display("FAIL starve_ld_data got %h want %h", bus.ld_dout, m_ld_dout);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int cyc;
    int n0;
    lat = 2;
    resp_en = 1'b0;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 23'h000040;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.owner !== 2'd2) begin errors++; $display("FAIL mid_inflight got owner=%0d want 2", bus.owner); end
    n0 = ack_log.size();
    #1 reset = 1'b1;
    #1;
    m_cpu_dout = 8'h00;
    m_ld_dout  = 8'h00;
    checks++;
    if ({bus.vid_ack, bus.cpu_ack, bus.ld_ack, bus.sdr_req, bus.sdr_we, bus.owner, bus.sdr_be} !== 9'b0) begin
      errors++;
      $display("FAIL mid_async_ctrl got %b want 0", {bus.vid_ack, bus.cpu_ack, bus.ld_ack, bus.sdr_req,
               bus.sdr_we, bus.owner, bus.sdr_be});
    end
    checks++;
    if ({bus.vid_data, bus.cpu_dout, bus.ld_dout, bus.sdr_addr} !== '0) begin
      errors++;
      $display("FAIL mid_async_data got vid=%h cpu=%h ld=%h addr=%h want zeros",
               bus.vid_data, bus.cpu_dout, bus.ld_dout, bus.sdr_addr);
    end
    bus.cpu_req = 1'b0;
    resp_en = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ack_log.size() != n0) begin errors++; $display("FAIL mid_no_ack got %0d acks want 0", ack_log.size() - n0); end
    reset = 1'b0;
    @(negedge clk);
    run_txn(2, 1'b0, 23'h000041, 8'h00, ok, cyc);
    m_cpu_dout = ref_rd(32'h41);
    checks++;
    if (!ok || bus.cpu_dout !== m_cpu_dout) begin
      errors++;
      $display("FAIL mid_recover got ok=%0d dout=%h want 1 %h", ok, bus.cpu_dout, m_cpu_dout);
    end
  endtask

  task automatic test_ready_idle;
    bit ok;
    int cyc;
    int n0;
    n0 = ack_log.size();
    @(negedge clk);
    bus.sdr_ready = 1'b1;
    bus.sdr_dout  = 16'hBEEF;
    @(negedge clk);
    bus.sdr_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ack_log.size() != n0 || bus.owner !== 2'd0 || bus.sdr_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready got acks=%0d owner=%0d sdr_req=%b want 0 0 0",
               ack_log.size() - n0, bus.owner, bus.sdr_req);
    end
    lat = 1;
    run_txn(2, 1'b0, 23'h000060, 8'h00, ok, cyc);
    m_cpu_dout = ref_rd(32'h60);
    checks++;
    if (!ok || cyc != 3 || bus.cpu_dout !== m_cpu_dout) begin
      errors++;
      $display("FAIL idle_then_read got ok=%0d cyc=%0d dout=%h want 1 3 %h", ok, cyc, bus.cpu_dout, m_cpu_dout);
    end
  endtask

  task automatic test_random;
    bit ok;
    int cyc, who, n0, wa;
    logic we;
    logic [AW-1:0] addr;
    logic [7:0] din;
    logic [1:0] exp_be;
    logic [15:0] exp_vid;
    for (int t = 0; t < 40; t++) begin
      who  = $urandom_range(1, 3);
      we   = (who == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      addr = AW'($urandom_range(0, 63));
      din  = 8'($urandom);
      lat  = $urandom_range(1, 4);
      n0   = ack_log.size();
      wa   = int'(addr[AW-1:1]);
      run_txn(who, we, addr, din, ok, cyc);
      exp_be = (who == 1) ? 2'b11 : (addr[0] ? 2'b10 : 2'b01);
      checks++;
      if (!ok || cyc != lat + 2) begin
        errors++;
        $display("FAIL rnd%0d_latency got ok=%0d cyc=%0d want 1 %0d", t, ok, cyc, lat + 2);
      end
      checks++;
      if (cmd_addr !== addr[AW-1:1] || cmd_be !== exp_be || cmd_we !== we) begin
        errors++;
        $display("FAIL rnd%0d_cmd got addr=%h be=%b we=%b want %h %b %b", t, cmd_addr, cmd_be, cmd_we,
                 addr[AW-1:1], exp_be, we);
      end
      if (we) begin
        ref_mem[int'(addr)] = din;
        checks++;
        if (cmd_din !== {din, din}) begin
          errors++;
          $display("FAIL rnd%0d_wdata got %h want %h", t, cmd_din, {din, din});
        end
        checks++;
        if (bus.cpu_dout !== m_cpu_dout || bus.ld_dout !== m_ld_dout) begin
          errors++;
          $display("FAIL rnd%0d_dout_kept got cpu=%h ld=%h want %h %h", t, bus.cpu_dout, bus.ld_dout,
                   m_cpu_dout, m_ld_dout);
        end
      end else if (ok && ack_log.size() > n0) begin
        exp_vid = {ref_rd(2 * wa + 1), ref_rd(2 * wa)};
        if (who == 2) m_cpu_dout = ref_rd(int'(addr));
        if (who == 3) m_ld_dout  = ref_rd(int'(addr));
        checks++;
        if (who == 1 && ack_log[n0].data !== exp_vid) begin
          errors++;
          $display("FAIL rnd%0d_vid got %h want %h", t, ack_log[n0].data, exp_vid);
        end else if (who != 1 && ack_log[n0].data[7:0] !== ref_rd(int'(addr))) begin
          errors++;
          $display("FAIL rnd%0d_byte got %h want %h", t, ack_log[n0].data[7:0], ref_rd(int'(addr)));
        end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b1;
    bus.vid_req = 1'b0; bus.vid_addr = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_din = '0;
    bus.ld_req  = 1'b0; bus.ld_we  = 1'b0; bus.ld_addr  = '0; bus.ld_din  = '0;
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_simultaneous();
    test_starvation();
    test_reset_mid();
    test_ready_idle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
